ad396x_mimo_data_interface: RTL and testbench

// Parametrised AD936x CMOS data-port interface for 1R1T or 2R2T operation. Sits between the baseband

---
 rtl/ad396x_mimo_data_interface.sv | 235 +++++++++++++++++++++++
 tb/tb_ad396x_mimo_data_interface.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad396x_mimo_data_interface.sv
// AD936x CMOS data-port interface: oversampled data_clk, per-slot I/Q (de)serialisation,
// RX sample FIFO, double-buffered TX word and sticky status flags.
module ad396x_mimo_data_interface #(
  parameter int unsigned DATA_WIDTH    = 12,
  parameter int unsigned NUM_CHANNELS  = 1,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   bbp_rx_data_i,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   bbp_rx_data_q,
  input  logic                                 bbp_rx_data_ready,
  output logic                                 bbp_rx_data_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   bbp_tx_data_i,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   bbp_tx_data_q,
  output logic                                 bbp_tx_data_ready,
  input  logic                                 bbp_tx_data_valid,
  input  logic [DATA_WIDTH-1:0]                ad396x_rx_data,
  input  logic                                 ad396x_rx_frame,
  input  logic                                 ad396x_data_clk,
  output logic                                 ad396x_data_clk_fb,
  output logic [DATA_WIDTH-1:0]                ad396x_tx_data,
  output logic                                 ad396x_tx_frame,
  input  logic                                 clear_status,
  output logic                                 rx_overflow,
  output logic                                 rx_frame_error,
  output logic                                 tx_underflow,
  output logic [$clog2(RX_FIFO_DEPTH+1)-1:0]   rx_fifo_level
);

  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned NC   = NUM_CHANNELS;
  localparam int unsigned S    = 2 * NC;
  localparam int unsigned SW   = $clog2(S);
  localparam int unsigned PW   = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned LW   = $clog2(RX_FIFO_DEPTH + 1);
  localparam int unsigned CHW  = NC * DW;
  localparam int unsigned SMPW = 2 * CHW;

  // Pin synchronisers; rx data/frame share the data_clk latency so slots line up with edges.
  logic          dclk_s1_q, dclk_s2_q, dclk_s3_q;
  logic [DW-1:0] rxd_s1_q, rxd_s2_q;
  logic          rxf_s1_q, rxf_s2_q;
  logic          evt;

  assign evt = dclk_s2_q & ~dclk_s3_q;

  // TX path
  logic [SW-1:0]         tx_slot_q, tx_slot_d;
  logic [S-1:0][DW-1:0]  bbp_tx_slots;
  logic [S-1:0][DW-1:0]  tx_buf_q, tx_buf_d, tx_shadow_q, tx_shadow_d;
  logic                  tx_buf_full_q, tx_buf_full_d, tx_armed_q, tx_armed_d;
  logic                  tx_ready_q, tx_ready_d;
  logic [DW-1:0]         tx_data_q, tx_data_d;
  logic                  tx_frame_q, tx_frame_d;
  logic                  tx_slot0, tx_uf_set;

  assign tx_slot0  = evt && (tx_slot_q == '0);
  assign tx_uf_set = tx_slot0 && !tx_buf_full_q && tx_armed_q;

  always_comb begin
    bbp_tx_slots = '0;
    for (int c = 0; c < int'(NC); c++) begin
      bbp_tx_slots[2*c]   = bbp_tx_data_i[c*DW +: DW];
      bbp_tx_slots[2*c+1] = bbp_tx_data_q[c*DW +: DW];
    end
  end

  always_comb begin
    tx_slot_d     = tx_slot_q;
    tx_buf_d      = tx_buf_q;
    tx_buf_full_d = tx_buf_full_q;
    tx_armed_d    = tx_armed_q;
    tx_shadow_d   = tx_shadow_q;
    tx_data_d     = tx_data_q;
    tx_frame_d    = tx_frame_q;
    tx_ready_d    = tx_slot0;
    if (tx_slot0) begin
      tx_shadow_d   = tx_buf_full_q ? tx_buf_q : '0;
      tx_buf_full_d = 1'b0;
    end
    if (evt) begin
      tx_slot_d  = (tx_slot_q == SW'(S - 1)) ? '0 : tx_slot_q + SW'(1);
      tx_data_d  = tx_shadow_d[tx_slot_q];
      tx_frame_d = tx_slot_q < SW'(NC);
    end
    // The ready pulse trails the slot-0 event, so a load never collides with the buffer hand-off.
    if (tx_ready_q && bbp_tx_data_valid) begin
      tx_buf_d      = bbp_tx_slots;
      tx_buf_full_d = 1'b1;
      tx_armed_d    = 1'b1;
    end
  end

  // RX path
  logic                  rx_aligned_q, rx_aligned_d, rx_prev_q;
  logic [SW-1:0]         rx_slot_q, rx_slot_d;
  logic [S-1:0][DW-1:0]  rx_slots_q, rx_slots_d, rx_full_slots;
  logic                  rx_push, rx_err_set, rx_rise, rx_exp;
  logic [CHW-1:0]        push_i, push_q;

  assign rx_rise = rxf_s2_q & ~rx_prev_q;
  assign rx_exp  = rx_slot_q < SW'(NC);

  always_comb begin
    rx_aligned_d = rx_aligned_q;
    rx_slot_d    = rx_slot_q;
    rx_slots_d   = rx_slots_q;
    rx_push      = 1'b0;
    rx_err_set   = 1'b0;
    if (evt) begin
      if (!rx_aligned_q || (rxf_s2_q != rx_exp)) begin
        rx_err_set = rx_aligned_q;
        if (rx_rise) begin
          rx_aligned_d  = 1'b1;
          rx_slots_d[0] = rxd_s2_q;
          rx_slot_d     = SW'(1);
        end else begin
          rx_aligned_d = 1'b0;
          rx_slot_d    = '0;
        end
      end else begin
        rx_slots_d[rx_slot_q] = rxd_s2_q;
        if (rx_slot_q == SW'(S - 1)) begin
          rx_push   = 1'b1;
          rx_slot_d = '0;
        end else begin
          rx_slot_d = rx_slot_q + SW'(1);
        end
      end
    end
  end

  always_comb begin
    rx_full_slots        = rx_slots_q;
    rx_full_slots[S-1]   = rxd_s2_q;
    push_i               = '0;
    push_q               = '0;
    for (int c = 0; c < int'(NC); c++) begin
      push_i[c*DW +: DW] = rx_full_slots[2*c];
      push_q[c*DW +: DW] = rx_full_slots[2*c+1];
    end
  end

  // RX FIFO
  logic [SMPW-1:0] fifo_q [RX_FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            fifo_full, fifo_pop, fifo_wr, fifo_drop;
  logic [SMPW-1:0] head;

  assign fifo_full = level_q == LW'(RX_FIFO_DEPTH);
  assign fifo_pop  = bbp_rx_data_ready && (level_q != '0);
  assign fifo_wr   = rx_push && (!fifo_full || fifo_pop);
  assign fifo_drop = rx_push && fifo_full && !fifo_pop;

  always_comb begin
    case ({fifo_wr, fifo_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_q[wr_ptr_q] <= {push_i, push_q};
  end

  assign head              = fifo_q[rd_ptr_q];
  assign bbp_rx_data_valid = level_q != '0;
  assign bbp_rx_data_i     = bbp_rx_data_valid ? head[SMPW-1 -: CHW] : '0;
  assign bbp_rx_data_q     = bbp_rx_data_valid ? head[CHW-1:0] : '0;
  assign rx_fifo_level     = level_q;

  // Stickies: a set in the same cycle wins over clear_status.
  logic ov_q, fe_q, uf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      {dclk_s1_q, dclk_s2_q, dclk_s3_q} <= '0;
      {rxd_s1_q, rxd_s2_q, rxf_s1_q, rxf_s2_q} <= '0;
      tx_slot_q     <= '0;
      tx_buf_q      <= '0;
      tx_buf_full_q <= 1'b0;
      tx_armed_q    <= 1'b0;
      tx_shadow_q   <= '0;
      tx_ready_q    <= 1'b0;
      tx_data_q     <= '0;
      tx_frame_q    <= 1'b0;
      rx_aligned_q  <= 1'b0;
      rx_prev_q     <= 1'b0;
      rx_slot_q     <= '0;
      rx_slots_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      {ov_q, fe_q, uf_q} <= '0;
    end else begin
      dclk_s1_q     <= ad396x_data_clk;
      dclk_s2_q     <= dclk_s1_q;
      dclk_s3_q     <= dclk_s2_q;
      rxd_s1_q      <= ad396x_rx_data;
      rxd_s2_q      <= rxd_s1_q;
      rxf_s1_q      <= ad396x_rx_frame;
      rxf_s2_q      <= rxf_s1_q;
      tx_slot_q     <= tx_slot_d;
      tx_buf_q      <= tx_buf_d;
      tx_buf_full_q <= tx_buf_full_d;
      tx_armed_q    <= tx_armed_d;
      tx_shadow_q   <= tx_shadow_d;
      tx_ready_q    <= tx_ready_d;
      tx_data_q     <= tx_data_d;
      tx_frame_q    <= tx_frame_d;
      rx_aligned_q  <= rx_aligned_d;
      rx_prev_q     <= evt ? rxf_s2_q : rx_prev_q;
      rx_slot_q     <= rx_slot_d;
      rx_slots_q    <= rx_slots_d;
      wr_ptr_q      <= fifo_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_q      <= fifo_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      level_q       <= level_d;
      ov_q          <= fifo_drop  | (ov_q & ~clear_status);
      fe_q          <= rx_err_set | (fe_q & ~clear_status);
      uf_q          <= tx_uf_set  | (uf_q & ~clear_status);
    end
  end

  assign ad396x_data_clk_fb = dclk_s2_q;
  assign ad396x_tx_data     = tx_data_q;
  assign ad396x_tx_frame    = tx_frame_q;
  assign bbp_tx_data_ready  = tx_ready_q;
  assign rx_overflow        = ov_q;
  assign rx_frame_error     = fe_q;
  assign tx_underflow       = uf_q;

endmodule

// File: tb/tb_ad396x_mimo_data_interface.sv
// Bench: a 1-channel and a 2-channel instance share clk/rst/data_clk; RX samples go through
// per-instance scoreboards, TX timing and stickies are checked directly.
module tb_ad396x_mimo_data_interface;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic data_clk, clear_status;

  // 1-channel instance
  logic [11:0] rxi1, rxq1, txi1, txq1, rxd1, txd1;
  logic        rdy1, rxv1, txr1, txv1, rxf1, fb1, txf1, ov1, fe1, uf1;
  logic [2:0]  lvl1;
  // 2-channel instance
  logic [23:0] rxi2, rxq2, txi2, txq2;
  logic [11:0] rxd2, txd2;
  logic        rdy2, rxv2, txr2, txv2, rxf2, fb2, txf2, ov2, fe2, uf2;
  logic [2:0]  lvl2;

  ad396x_mimo_data_interface #(.DATA_WIDTH(12), .NUM_CHANNELS(1), .RX_FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst),
    .bbp_rx_data_i(rxi1), .bbp_rx_data_q(rxq1), .bbp_rx_data_ready(rdy1),
    .bbp_rx_data_valid(rxv1), .bbp_tx_data_i(txi1), .bbp_tx_data_q(txq1),
    .bbp_tx_data_ready(txr1), .bbp_tx_data_valid(txv1), .ad396x_rx_data(rxd1),
    .ad396x_rx_frame(rxf1), .ad396x_data_clk(data_clk), .ad396x_data_clk_fb(fb1),
    .ad396x_tx_data(txd1), .ad396x_tx_frame(txf1), .clear_status(clear_status),
    .rx_overflow(ov1), .rx_frame_error(fe1), .tx_underflow(uf1), .rx_fifo_level(lvl1)
  );

  ad396x_mimo_data_interface #(.DATA_WIDTH(12), .NUM_CHANNELS(2), .RX_FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst),
    .bbp_rx_data_i(rxi2), .bbp_rx_data_q(rxq2), .bbp_rx_data_ready(rdy2),
    .bbp_rx_data_valid(rxv2), .bbp_tx_data_i(txi2), .bbp_tx_data_q(txq2),
    .bbp_tx_data_ready(txr2), .bbp_tx_data_valid(txv2), .ad396x_rx_data(rxd2),
    .ad396x_rx_frame(rxf2), .ad396x_data_clk(data_clk), .ad396x_data_clk_fb(fb2),
    .ad396x_tx_data(txd2), .ad396x_tx_frame(txf2), .clear_status(clear_status),
    .rx_overflow(ov2), .rx_frame_error(fe2), .tx_underflow(uf2), .rx_fifo_level(lvl2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards hold expected {i, q} per accepted RX sample.
  logic [23:0] exp1_q[$];
  logic [47:0] exp2_q[$];

  always @(negedge clk) begin
    #1;
    if (!rst && rxv1 && rdy1) begin
      if (exp1_q.size() == 0) chk("rx1_unexpected_sample", {rxi1, rxq1}, 64'hDEAD);
      else chk("rx1_sample", {rxi1, rxq1}, exp1_q.pop_front());
    end
    if (!rst && rxv2 && rdy2) begin
      if (exp2_q.size() == 0) chk("rx2_unexpected_sample", {rxi2, rxq2}, 64'hDEAD);
      else chk("rx2_sample", {rxi2, rxq2}, exp2_q.pop_front());
    end
  end

  int rdy_cnt1 = 0;
  always @(negedge clk) if (!rst && txr1) rdy_cnt1++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Captures relative to the data_clk rise: fb at +1/+2, outputs at +2/+3, ready at +3/+4.
  logic        fb_p1, fb_p2, txf_p2, txf_p3, rdy_p3, rdy_p4, v2_p2, v2_p3;
  logic [11:0] txd_p3;

  task automatic dclk_period(input logic [11:0] d1, input logic f1,
                             input logic [11:0] d2, input logic f2);
    @(negedge clk);
    rxd1 = d1; rxf1 = f1; rxd2 = d2; rxf2 = f2; data_clk = 1'b1;
    @(posedge clk); #1 fb_p1 = fb1;
    @(posedge clk); #1 fb_p2 = fb1; txf_p2 = txf1; v2_p2 = rxv2;
    @(posedge clk); #1 txf_p3 = txf1; txd_p3 = txd1; rdy_p3 = txr1; v2_p3 = rxv2;
    @(posedge clk); #1 rdy_p4 = txr1;
    repeat (7) @(negedge clk);
    data_clk = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic tx_slot(input string name, input logic ef, input logic [11:0] ed,
                         input logic er);
    dclk_period(12'h0, 1'b0, 12'h0, 1'b0);
    chk({name, "_fb_p1"}, fb_p1, 1'b0);
    chk({name, "_fb_p2"}, fb_p2, 1'b1);
    chk({name, "_frame"}, txf_p3, ef);
    chk({name, "_data"}, txd_p3, ed);
    chk({name, "_ready"}, rdy_p3, er);
    chk({name, "_ready_p4"}, rdy_p4, 1'b0);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_status = 1'b1;
    @(negedge clk); clear_status = 1'b0;
    #1;
  endtask

  // u1 and u2 RX slot streams for the frame-error test.
  logic [11:0] fe_d1 [7] = '{12'h0AA, 12'h055, 12'h001, 12'h002, 12'h000, 12'h0F0, 12'h30C};
  logic        fe_f1 [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [11:0] fe_d2 [7] = '{12'h901, 12'h902, 12'h000, 12'hA01, 12'hA02, 12'hA03, 12'hA04};
  logic        fe_f2 [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    logic any_out;
    logic [11:0] sd;

    data_clk = 0; clear_status = 0;
    {txi1, txq1, txv1, rdy1, rxd1, rxf1} = '0;
    {txi2, txq2, txv2, rdy2, rxd2, rxf2} = '0;

    // Reset held while every input toggles randomly.
    @(posedge clk);
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      any_out = |{rxi1, rxq1, rxv1, txr1, fb1, txd1, txf1, ov1, fe1, uf1, lvl1,
                  rxi2, rxq2, rxv2, txr2, fb2, txd2, txf2, ov2, fe2, uf2, lvl2};
      chk("reset_outputs_zero", any_out, 1'b0);
      data_clk = 1'($urandom); clear_status = 1'($urandom);
      txi1 = 12'($urandom); txq1 = 12'($urandom); txv1 = 1'($urandom); rdy1 = 1'($urandom);
      rxd1 = 12'($urandom); rxf1 = 1'($urandom);
      txi2 = 24'($urandom); txq2 = 24'($urandom); txv2 = 1'($urandom); rdy2 = 1'($urandom);
      rxd2 = 12'($urandom); rxf2 = 1'($urandom);
    end
    @(negedge clk);
    data_clk = 0; clear_status = 0;
    {txi1, txq1, txv1, rdy1, rxd1, rxf1} = '0;
    {txi2, txq2, txv2, rdy2, rxd2, rxf2} = '0;
    rst = 0;
    repeat (5) @(negedge clk);
    #1;
    chk("post_reset_level", {lvl1, lvl2}, 6'h0);
    chk("post_reset_valid", {rxv1, rxv2}, 2'b00);

    // TX on the 1-channel instance; the buffer starts empty so frame 1 carries zeros.
    txi1 = 12'h0F0; txq1 = 12'h30C; txv1 = 1'b1;
    rdy_cnt1 = 0;
    tx_slot("f1_s0", 1'b1, 12'h000, 1'b1);
    chk("f1_out_late", txf_p2, 1'b0);
    chk("f1_no_underflow", uf1, 1'b0);
    tx_slot("f1_s1", 1'b0, 12'h000, 1'b0);
    tx_slot("f2_s0", 1'b1, 12'h0F0, 1'b1);
    txi1 = 12'hABC; txq1 = 12'h123;
    tx_slot("f2_s1", 1'b0, 12'h30C, 1'b0);
    tx_slot("f3_s0", 1'b1, 12'h0F0, 1'b1);
    txv1 = 1'b0;
    tx_slot("f3_s1", 1'b0, 12'h30C, 1'b0);
    tx_slot("f4_s0", 1'b1, 12'hABC, 1'b1);
    chk("f4_no_underflow", uf1, 1'b0);
    tx_slot("f4_s1", 1'b0, 12'h123, 1'b0);
    tx_slot("f5_s0", 1'b1, 12'h000, 1'b1);
    chk("f5_underflow", uf1, 1'b1);
    tx_slot("f5_s1", 1'b0, 12'h000, 1'b0);
    chk("tx_ready_pulses", rdy_cnt1, 5);
    pulse_clear();
    chk("underflow_cleared", uf1, 1'b0);

    // 2-channel RX: one frame becomes one sample.
    rdy1 = 1'b1; rdy2 = 1'b1;
    exp2_q.push_back({24'h333111, 24'h444222});
    dclk_period(12'h0, 1'b0, 12'h111, 1'b1);
    dclk_period(12'h0, 1'b0, 12'h222, 1'b1);
    dclk_period(12'h0, 1'b0, 12'h333, 1'b0);
    dclk_period(12'h0, 1'b0, 12'h444, 1'b0);
    chk("rx_valid_p2", v2_p2, 1'b0);
    chk("rx_valid_p3", v2_p3, 1'b1);
    chk("rx_single_drained", exp2_q.size(), 0);

    // Overflow: five frames into a depth-4 FIFO with the BBP stalled.
    @(negedge clk); rdy2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) begin
        sd = 12'h500 + 12'(k * 16 + j);
        dclk_period(12'h0, 1'b0, sd, (j < 2));
      end
    end
    #1;
    chk("ovf_level", lvl2, 3'd4);
    chk("ovf_flag", ov2, 1'b1);
    chk("ovf_head_i", rxi2, 24'h502500);
    chk("ovf_head_q", rxq2, 24'h503501);
    exp2_q.push_back({24'h502500, 24'h503501});
    exp2_q.push_back({24'h512510, 24'h513511});
    exp2_q.push_back({24'h522520, 24'h523521});
    exp2_q.push_back({24'h532530, 24'h533531});
    @(negedge clk); rdy2 = 1'b1;
    repeat (8) @(negedge clk);
    #2;
    chk("ovf_drained", exp2_q.size(), 0);
    chk("ovf_level_empty", lvl2, 3'd0);
    pulse_clear();
    chk("ovf_cleared", ov2, 1'b0);
    chk("fe_clear_start", {fe1, fe2}, 2'b00);

    // Frame-pattern violations: partial samples discarded, next good frame accepted.
    exp1_q.push_back({12'h0AA, 12'h055});
    exp1_q.push_back({12'h0F0, 12'h30C});
    exp2_q.push_back({24'hA03A01, 24'hA04A02});
    for (int s = 0; s < 7; s++) dclk_period(fe_d1[s], fe_f1[s], fe_d2[s], fe_f2[s]);
    repeat (3) @(negedge clk);
    #2;
    chk("fe1_flag", fe1, 1'b1);
    chk("fe2_flag", fe2, 1'b1);
    chk("fe1_queue_drained", exp1_q.size(), 0);
    chk("fe2_queue_drained", exp2_q.size(), 0);
    chk("fe_no_overflow", {ov1, ov2}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
